// File: rtl/sseg_scan_receiver.sv
// Rebuilds the four hex digits and decimal points shown on a multiplexed seven-segment bus.
// Define SSEG_RX_BIN_EN to add the registered 0-9999 binary value on value_bin.
module sseg_scan_receiver #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  sseg,
    input  logic        dp,
    output logic [15:0] digits,
    output logic [3:0]  dps,
    output logic        frame_done,
    output logic        frame_valid,
    output logic        seg_err,
    output logic [13:0] value_bin,
    output logic        bcd_err,
    output logic [1:0]  dbg_state   // 0 IDLE, 1 SETTLE, 2 CAPTURE, 3 HOLD
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } state_t;

    localparam logic [8:0] LP_SETTLE = 9'(SETTLE_CYCLES);

    logic [3:0]  r_an_m, r_an_s;
    logic [6:0]  r_sseg_m, r_sseg_s;
    logic        r_dp_m, r_dp_s;
    state_t      r_state, w_next;
    logic [11:0] r_ref;
    logic [7:0]  r_cnt;
    logic [15:0] r_stage, r_digits;
    logic [3:0]  r_stage_dp, r_seen, r_dps;
    logic        r_frame_done, r_frame_valid, r_seg_err;

    logic [11:0] w_cur;
    logic        w_an_ok, w_mismatch, w_settled;
    logic        w_load_ref, w_inc_cnt, w_capture;
    logic [3:0]  w_idx_oh;
    logic        w_glyph_ok;
    logic [3:0]  w_glyph_val;
    logic [15:0] w_stage_nx;
    logic [3:0]  w_stage_dp_nx, w_seen_nx;
    logic        w_done;

    function automatic logic f_over9(input logic [15:0] d);
        return (d[15:12] > 4'd9) || (d[11:8] > 4'd9) || (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_an_m   <= 4'd0;
            r_an_s   <= 4'd0;
            r_sseg_m <= 7'd0;
            r_sseg_s <= 7'd0;
            r_dp_m   <= 1'b0;
            r_dp_s   <= 1'b0;
        end else begin
            r_an_m   <= an;
            r_an_s   <= r_an_m;
            r_sseg_m <= sseg;
            r_sseg_s <= r_sseg_m;
            r_dp_m   <= dp;
            r_dp_s   <= r_dp_m;
        end
    end

    // Reference layout: {an[3:0], sseg[6:0], dp}; any field change is one mismatch.
    assign w_cur      = {r_an_s, r_sseg_s, r_dp_s};
    assign w_mismatch = (w_cur != r_ref);
    assign w_settled  = ({1'b0, r_cnt} + 9'd1) >= LP_SETTLE;
    assign w_idx_oh   = ~r_ref[11:8];

    always_comb begin
        w_an_ok = 1'b0;
        case (r_an_s)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: w_an_ok = 1'b1;
            default:                            w_an_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_an_ok) w_next = (LP_SETTLE <= 9'd1) ? ST_CAPTURE : ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!w_an_ok)        w_next = ST_IDLE;
                else if (w_mismatch) w_next = ST_SETTLE;
                else if (w_settled)  w_next = ST_CAPTURE;
                else                 w_next = ST_SETTLE;
            end
            ST_CAPTURE: w_next = ST_HOLD;
            ST_HOLD: begin
                if (w_mismatch) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_load_ref = 1'b0;
        w_inc_cnt  = 1'b0;
        w_capture  = 1'b0;
        case (r_state)
            ST_IDLE:    w_load_ref = w_an_ok;
            ST_SETTLE: begin
                w_load_ref = w_an_ok && w_mismatch;
                w_inc_cnt  = w_an_ok && !w_mismatch && !w_settled;
            end
            ST_CAPTURE: w_capture = 1'b1;
            default:    w_capture = 1'b0;
        endcase
    end

    // Segment pattern is {g..a}, active-low.
    always_comb begin
        w_glyph_ok  = 1'b1;
        w_glyph_val = 4'h0;
        case (r_ref[7:1])
            7'h40: w_glyph_val = 4'h0;
            7'h79: w_glyph_val = 4'h1;
            7'h24: w_glyph_val = 4'h2;
            7'h30: w_glyph_val = 4'h3;
            7'h19: w_glyph_val = 4'h4;
            7'h12: w_glyph_val = 4'h5;
            7'h02: w_glyph_val = 4'h6;
            7'h78: w_glyph_val = 4'h7;
            7'h00: w_glyph_val = 4'h8;
            7'h10: w_glyph_val = 4'h9;
            7'h08: w_glyph_val = 4'hA;
            7'h03: w_glyph_val = 4'hB;
            7'h46: w_glyph_val = 4'hC;
            7'h21: w_glyph_val = 4'hD;
            7'h06: w_glyph_val = 4'hE;
            7'h0E: w_glyph_val = 4'hF;
            default: w_glyph_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_stage_nx    = r_stage;
        w_stage_dp_nx = r_stage_dp;
        w_seen_nx     = r_seen;
        if (w_capture) begin
            w_stage_dp_nx = (r_stage_dp & ~w_idx_oh) | (w_idx_oh & {4{~r_ref[0]}});
            if (w_glyph_ok) begin
                w_seen_nx = r_seen | w_idx_oh;
                for (int i = 0; i < 4; i++) begin
                    if (w_idx_oh[i]) w_stage_nx[4*i +: 4] = w_glyph_val;
                end
            end
        end
    end

    assign w_done = w_capture && (w_seen_nx == 4'hF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ref         <= 12'd0;
            r_cnt         <= 8'd0;
            r_stage       <= 16'd0;
            r_stage_dp    <= 4'd0;
            r_seen        <= 4'd0;
            r_digits      <= 16'd0;
            r_dps         <= 4'd0;
            r_frame_done  <= 1'b0;
            r_frame_valid <= 1'b0;
            r_seg_err     <= 1'b0;
        end else begin
            if (w_load_ref) begin
                r_ref <= w_cur;
                r_cnt <= 8'd1;
            end else if (w_inc_cnt) begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_stage      <= w_stage_nx;
            r_stage_dp   <= w_stage_dp_nx;
            r_seen       <= w_done ? 4'h0 : w_seen_nx;
            r_seg_err    <= w_capture && !w_glyph_ok;
            r_frame_done <= w_done;
            if (w_done) begin
                r_digits      <= w_stage_nx;
                r_dps         <= w_stage_dp_nx;
                r_frame_valid <= 1'b1;
            end
        end
    end

`ifdef SSEG_RX_BIN_EN
    logic [13:0] r_value, w_value_nx;

    assign w_value_nx = 14'(w_stage_nx[15:12]) * 14'd1000 + 14'(w_stage_nx[11:8]) * 14'd100
                      + 14'(w_stage_nx[7:4]) * 14'd10 + 14'(w_stage_nx[3:0]);

    // A frame holding any non-decimal digit leaves the previous value in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                             r_value <= 14'd0;
        else if (w_done && !f_over9(w_stage_nx)) r_value <= w_value_nx;
    end

    assign value_bin = r_value;
`else
    assign value_bin = 14'd0;
`endif

    assign digits      = r_digits;
    assign dps         = r_dps;
    assign frame_done  = r_frame_done;
    assign frame_valid = r_frame_valid;
    assign seg_err     = r_seg_err;
    assign bcd_err     = f_over9(r_digits);
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_sseg_scan_receiver.sv
// Bench for sseg_scan_receiver: table of whole frames, hand-written corner sequences,
// and a randomized bus checked against a slot-level model of the receiver.
`timescale 1ns/1ps
module tb_sseg_scan_receiver;
    localparam int S    = 16;
    localparam int SLOT = S + 6;
`ifdef SSEG_RX_BIN_EN
    localparam bit BIN = 1'b1;
`else
    localparam bit BIN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic [3:0] an   = 4'hF;
    logic [6:0] sseg = 7'h7F;
    logic       dp   = 1'b1;

    logic [15:0] digits, digits1;
    logic [3:0]  dps, dps1;
    logic        frame_done, frame_valid, seg_err, bcd_err;
    logic        frame_done1, frame_valid1, seg_err1, bcd_err1;
    logic [13:0] value_bin, value_bin1;
    logic [1:0]  dbg_state, dbg_state1;

    always #5 clk = ~clk;

    sseg_scan_receiver #(.SETTLE_CYCLES(S)) u_dut (
        .clk(clk), .reset(reset), .an(an), .sseg(sseg), .dp(dp),
        .digits(digits), .dps(dps), .frame_done(frame_done), .frame_valid(frame_valid),
        .seg_err(seg_err), .value_bin(value_bin), .bcd_err(bcd_err), .dbg_state(dbg_state)
    );

    sseg_scan_receiver #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .reset(reset), .an(an), .sseg(sseg), .dp(dp),
        .digits(digits1), .dps(dps1), .frame_done(frame_done1), .frame_valid(frame_valid1),
        .seg_err(seg_err1), .value_bin(value_bin1), .bcd_err(bcd_err1), .dbg_state(dbg_state1)
    );

    int total = 0;
    int bad   = 0;

    // Observed frames: {digits, dps, value_bin, bcd_err}
    logic [34:0] obs_q[$];
    logic [34:0] exp_q[$];
    int obs_rd = 0;
    int se_cnt = 0;
    int se1_cnt = 0;
    int fd1_cnt = 0;

    always @(negedge clk) begin
        if (frame_done) obs_q.push_back({digits, dps, value_bin, bcd_err});
        if (seg_err) se_cnt++;
        if (seg_err1) se1_cnt++;
        if (frame_done1) fd1_cnt++;
    end

    logic [6:0] glyph_tab [16];

    typedef struct {
        logic [27:0] g;     // {g3, g2, g1, g0}
        logic [3:0]  dpn;
        logic [15:0] dig;
        logic [3:0]  dps;
        logic        bcd;
        logic [13:0] val;
    } vec_t;
    vec_t vt[6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        an = a; sseg = s; dp = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show_frame(input logic [27:0] g, input logic [3:0] dpn, input int n);
        show(4'b1110, g[6:0],   dpn[0], n);
        show(4'b1101, g[13:7],  dpn[1], n);
        show(4'b1011, g[20:14], dpn[2], n);
        show(4'b0111, g[27:21], dpn[3], n);
    endtask

    task automatic do_reset();
        an = 4'hF; sseg = 7'h7F; dp = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 obs_rd = obs_q.size();
    endtask

    task automatic expect_frame(input string name, input logic [15:0] dig, input logic [3:0] dpsx,
                                input logic bcd, input logic [13:0] val);
        logic [34:0] o;
        int k;
        k = 0;
        while (obs_q.size() <= obs_rd && k < 60) begin
            @(posedge clk); #1; k++;
        end
        if (obs_q.size() <= obs_rd) begin
            total++; bad++;
            $display("FAIL %s: no frame_done within 60 cycles", name);
        end else begin
            o = obs_q[obs_rd];
            obs_rd++;
            check({name, " digits"}, 64'(o[34:19]), 64'(dig));
            check({name, " dps"}, 64'(o[18:15]), 64'(dpsx));
            check({name, " value_bin"}, 64'(o[14:1]), 64'(val));
            check({name, " bcd_err"}, 64'(o[0]), 64'(bcd));
            repeat (4) @(posedge clk);
            #1 check({name, " extra frame_done"}, 64'(obs_q.size() - obs_rd), 64'd0);
        end
    endtask

    function automatic int glyph_index(input logic [6:0] s);
        for (int j = 0; j < 16; j++) if (glyph_tab[j] == s) return j;
        return -1;
    endfunction

    // Slot-level reference state
    logic [3:0] m_st [4];
    logic [3:0] m_dp;
    logic [3:0] m_seen;
    int         m_prev_val;
    int         exp_se;

    task automatic model_slot(input logic [3:0] a, input logic [6:0] s, input logic d);
        int idx, gi, v;
        logic [15:0] dg;
        logic over;
        if ($countones(~a) != 1) return;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) idx = i;
        m_dp[idx] = !d;
        gi = glyph_index(s);
        if (gi < 0) begin
            exp_se++;
            return;
        end
        m_st[idx] = 4'(gi);
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
            dg = {m_st[3], m_st[2], m_st[1], m_st[0]};
            over = 1'b0;
            for (int i = 0; i < 4; i++) if (m_st[i] > 4'd9) over = 1'b1;
            if (!over) m_prev_val = m_st[3] * 1000 + m_st[2] * 100 + m_st[1] * 10 + m_st[0];
            v = BIN ? m_prev_val : 0;
            exp_q.push_back({dg, m_dp, 14'(v), over});
            m_seen = 4'h0;
        end
    endtask

    initial begin
        int nonidle, se_base, fd1_base, pend, nmin, n;
        logic [3:0] ra;
        logic [6:0] rs;
        logic rd;
        logic [11:0] prev_pat;
        bit long_slot;

        glyph_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        vt[0] = '{g: {7'h79, 7'h24, 7'h30, 7'h19}, dpn: 4'b1111, dig: 16'h1234, dps: 4'b0000, bcd: 1'b0, val: 14'd1234};
        vt[1] = '{g: {7'h40, 7'h79, 7'h24, 7'h30}, dpn: 4'b1110, dig: 16'h0123, dps: 4'b0001, bcd: 1'b0, val: 14'd123};
        vt[2] = '{g: {7'h19, 7'h12, 7'h02, 7'h78}, dpn: 4'b0111, dig: 16'h4567, dps: 4'b1000, bcd: 1'b0, val: 14'd4567};
        vt[3] = '{g: {7'h00, 7'h10, 7'h08, 7'h03}, dpn: 4'b1111, dig: 16'h89AB, dps: 4'b0000, bcd: 1'b1, val: 14'd4567};
        vt[4] = '{g: {7'h46, 7'h21, 7'h06, 7'h0E}, dpn: 4'b0000, dig: 16'hCDEF, dps: 4'b1111, bcd: 1'b1, val: 14'd4567};
        vt[5] = '{g: {7'h40, 7'h40, 7'h40, 7'h0E}, dpn: 4'b1011, dig: 16'h000F, dps: 4'b0100, bcd: 1'b1, val: 14'd4567};

        do_reset();
        check("reset digits", 64'(digits), 64'd0);
        check("reset dps", 64'(dps), 64'd0);
        check("reset frame_done", 64'(frame_done), 64'd0);
        check("reset frame_valid", 64'(frame_valid), 64'd0);
        check("reset seg_err", 64'(seg_err), 64'd0);
        check("reset value_bin", 64'(value_bin), 64'd0);
        check("reset bcd_err", 64'(bcd_err), 64'd0);
        check("reset state", 64'(dbg_state), 64'd0);

        for (int i = 0; i < 6; i++) begin
            show_frame(vt[i].g, vt[i].dpn, SLOT);
            expect_frame($sformatf("table %0d", i), vt[i].dig, vt[i].dps, vt[i].bcd,
                         BIN ? vt[i].val : 14'd0);
            check($sformatf("table %0d live bcd_err", i), 64'(bcd_err), 64'(vt[i].bcd));
        end
        check("frame_valid after table", 64'(frame_valid), 64'd1);

        // Reset mid-frame: partial frame must be discarded at once.
        show(4'b1110, 7'h10, 1'b1, SLOT);
        show(4'b1101, 7'h10, 1'b1, SLOT);
        show(4'b1011, 7'h10, 1'b1, SLOT);
        reset = 1'b1;
        #1;
        check("async reset frame_valid", 64'(frame_valid), 64'd0);
        check("async reset digits", 64'(digits), 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        obs_rd = obs_q.size();
        show(4'b1011, 7'h10, 1'b1, SLOT);
        check("post reset no frame", 64'(obs_q.size() - obs_rd), 64'd0);
        check("post reset frame_valid", 64'(frame_valid), 64'd0);
        show_frame({7'h10, 7'h10, 7'h10, 7'h10}, 4'hF, SLOT);
        expect_frame("9999", 16'h9999, 4'h0, 1'b0, BIN ? 14'd9999 : 14'd0);
        check("9999 frame_valid", 64'(frame_valid), 64'd1);

        // Short glitch showing glyph 8 inside the digit-2 slot.
        do_reset();
        se_base = se_cnt;
        show(4'b1110, 7'h19, 1'b1, SLOT);
        show(4'b1101, 7'h30, 1'b1, SLOT);
        show(4'b1011, 7'h24, 1'b1, 4);
        show(4'b1011, 7'h00, 1'b1, 5);
        show(4'b1011, 7'h24, 1'b1, SLOT);
        show(4'b0111, 7'h79, 1'b1, SLOT);
        expect_frame("glitch", 16'h1234, 4'h0, 1'b0, BIN ? 14'd1234 : 14'd0);
        check("glitch seg_err", 64'(se_cnt - se_base), 64'd0);

        // Invalid glyph on digit 1 blocks the frame until a valid one arrives.
        do_reset();
        se_base = se_cnt;
        show(4'b1110, 7'h19, 1'b1, SLOT);
        show(4'b1101, 7'h7F, 1'b1, SLOT);
        show(4'b1011, 7'h24, 1'b1, SLOT);
        show(4'b0111, 7'h79, 1'b1, SLOT);
        check("invalid seg_err count", 64'(se_cnt - se_base), 64'd1);
        check("invalid no frame", 64'(obs_q.size() - obs_rd), 64'd0);
        show(4'b1101, 7'h30, 1'b1, SLOT);
        expect_frame("invalid recover", 16'h1234, 4'h0, 1'b0, BIN ? 14'd1234 : 14'd0);

        // Two anodes low counts as blank.
        show(4'hF, 7'h7F, 1'b1, 5);
        se_base = se_cnt;
        nonidle = 0;
        an = 4'b1100; sseg = 7'h19; dp = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (dbg_state != 2'd0) nonidle++;
        end
        check("blank an non-idle cycles", 64'(nonidle), 64'd0);
        check("blank an seg_err", 64'(se_cnt - se_base), 64'd0);
        check("blank an no frame", 64'(obs_q.size() - obs_rd), 64'd0);

        // SETTLE_CYCLES=1 instance captures 3-cycle slots; the default one ignores them.
        do_reset();
        fd1_base = fd1_cnt;
        se_base = se1_cnt;
        show(4'b1110, 7'h12, 1'b1, 3);
        show(4'b1101, 7'h02, 1'b1, 3);
        show(4'b1011, 7'h78, 1'b1, 3);
        show(4'b0111, 7'h00, 1'b1, 3);
        show(4'hF, 7'h7F, 1'b1, 6);
        check("s1 frame count", 64'(fd1_cnt - fd1_base), 64'd1);
        check("s1 digits", 64'(digits1), 64'h8765);
        check("s1 dps", 64'(dps1), 64'd0);
        check("s1 value_bin", 64'(value_bin1), BIN ? 64'd8765 : 64'd0);
        check("s1 bcd_err", 64'(bcd_err1), 64'd0);
        check("s1 frame_valid", 64'(frame_valid1), 64'd1);
        check("s1 seg_err", 64'(se1_cnt - se_base), 64'd0);
        check("s1 idle after blank", 64'(dbg_state1), 64'd0);
        check("short slots ignored", 64'(obs_q.size() - obs_rd), 64'd0);

        // Randomized bus against the slot-level model.
        do_reset();
        se_base = se_cnt;
        for (int i = 0; i < 4; i++) m_st[i] = 4'd0;
        m_dp = 4'd0; m_seen = 4'd0; m_prev_val = 0; exp_se = 0;
        prev_pat = {4'hF, 7'h7F, 1'b1};
        for (int t = 0; t < 150; t++) begin
            do begin
                if ($urandom_range(0, 9) < 8) ra = 4'hF ^ 4'(1 << $urandom_range(0, 3));
                else case ($urandom_range(0, 3))
                    0: ra = 4'hF;
                    1: ra = 4'h0;
                    2: ra = 4'b0011;
                    default: ra = 4'b1010;
                endcase
                if ($urandom_range(0, 9) < 8) rs = glyph_tab[$urandom_range(0, 15)];
                else begin
                    rs = 7'($urandom);
                    while (glyph_index(rs) >= 0) rs = 7'($urandom);
                end
                rd = 1'($urandom_range(0, 1));
            end while ({ra, rs, rd} == prev_pat);
            prev_pat = {ra, rs, rd};
            long_slot = ($urandom_range(0, 3) != 0);
            n = long_slot ? $urandom_range(S + 4, S + 12) : $urandom_range(1, S - 3);
            if (long_slot) model_slot(ra, rs, rd);
            show(ra, rs, rd, n);
        end
        show(4'hF, 7'h7F, 1'b1, 40);
        pend = obs_q.size() - obs_rd;
        check("random frame count", 64'(pend), 64'(exp_q.size()));
        nmin = (pend < exp_q.size()) ? pend : exp_q.size();
        for (int i = 0; i < nmin; i++)
            check($sformatf("random frame %0d", i), 64'(obs_q[obs_rd + i]), 64'(exp_q[i]));
        check("random seg_err count", 64'(se_cnt - se_base), 64'(exp_se));
        check("random frame_valid", 64'(frame_valid), 64'(exp_q.size() > 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
